// File: rtl/alu_pwr_seq.sv
// Power sequencer and start arbiter for the power-gated ALU domain.
// Steps power, domain reset and isolation in a fixed order and issues queued starts only in ON.
module alu_pwr_seq #(
   parameter int unsigned RAMP_CYCLES = 8,
   parameter int unsigned IDLE_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_on,
   input  logic       op_req,
   input  logic       alu_busy,
   output logic       alu_start,
   output logic       op_grant,
   output logic       op_drop,
   output logic       alu_pwr_en,
   output logic       iso_en,
   output logic       alu_rst_n,
   output logic       ready,
   output logic [2:0] pwr_state
);

   localparam logic [2:0] ST_OFF  = 3'd0;
   localparam logic [2:0] ST_RAMP = 3'd1;
   localparam logic [2:0] ST_REL  = 3'd2;
   localparam logic [2:0] ST_ON   = 3'd3;
   localparam logic [2:0] ST_ISO  = 3'd4;
   localparam logic [2:0] ST_PDN  = 3'd5;

   localparam logic [7:0] RAMP_LAST = 8'(RAMP_CYCLES - 1);
   localparam logic [7:0] IDLE_MAX  = 8'(IDLE_CYCLES);
   localparam logic       IDLE_EN   = (IDLE_CYCLES != 0);

   logic [2:0] r_state;
   logic [7:0] r_ramp_cnt;
   logic [7:0] r_idle_cnt;
   logic       r_pend;
   logic       r_alu_start;
   logic       r_op_drop;
   logic       r_pwr_en;
   logic       r_iso_en;
   logic       r_alu_rst_n;
   logic       r_ready;

   logic [2:0] w_state_d;
   logic       w_in_on;
   logic       w_issue;
   logic       w_drop;
   logic       w_activity;
   logic       w_idle_done;
   logic       w_enter_ramp;
   logic       w_enter_on;
   logic       w_pend_d;
   logic       w_pwr_en_d;
   logic       w_iso_en_d;
   logic       w_alu_rst_n_d;

   assign w_in_on     = (r_state == ST_ON);
   assign w_issue     = w_in_on & r_pend & ~alu_busy;
   assign w_drop      = op_req & r_pend & ~w_issue;
   assign w_activity  = sw_on | r_pend | op_req | alu_busy | r_alu_start;
   assign w_idle_done = IDLE_EN & (r_idle_cnt == IDLE_MAX);

   // A request arriving on the issue cycle takes the slot the issue frees.
   assign w_pend_d = w_issue ? op_req : (r_pend | op_req);

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_OFF:  if (sw_on | op_req | r_pend) w_state_d = ST_RAMP;
         ST_RAMP: if (r_ramp_cnt == RAMP_LAST) w_state_d = ST_REL;
         ST_REL:  w_state_d = ST_ON;
         ST_ON: begin
            if (~sw_on & ~r_pend & ~alu_busy & ~op_req & w_idle_done) w_state_d = ST_ISO;
         end
         ST_ISO:  w_state_d = ST_PDN;
         ST_PDN:  w_state_d = ST_OFF;
         default: w_state_d = ST_OFF;
      endcase
   end

   assign w_enter_ramp = (w_state_d == ST_RAMP) & (r_state != ST_RAMP);
   assign w_enter_on   = (w_state_d == ST_ON) & ~w_in_on;

   // Power controls are decoded from the next state so they register together with it.
   always_comb begin
      w_pwr_en_d    = 1'b1;
      w_iso_en_d    = 1'b1;
      w_alu_rst_n_d = 1'b0;
      case (w_state_d)
         ST_RAMP: ;
         ST_REL:  w_alu_rst_n_d = 1'b1;
         ST_ON: begin
            w_iso_en_d    = 1'b0;
            w_alu_rst_n_d = 1'b1;
         end
         ST_ISO:  w_alu_rst_n_d = 1'b1;
         ST_PDN:  ;
         default: w_pwr_en_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_OFF;
         r_pwr_en    <= 1'b0;
         r_iso_en    <= 1'b1;
         r_alu_rst_n <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_pwr_en    <= w_pwr_en_d;
         r_iso_en    <= w_iso_en_d;
         r_alu_rst_n <= w_alu_rst_n_d;
         r_ready     <= (w_state_d == ST_ON);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ramp_cnt <= 8'd0;
      end else if (w_enter_ramp) begin
         r_ramp_cnt <= 8'd0;
      end else if (r_state == ST_RAMP) begin
         r_ramp_cnt <= r_ramp_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= 8'd0;
      end else if (w_enter_on) begin
         r_idle_cnt <= 8'd0;
      end else if (w_in_on) begin
         if (w_activity) begin
            r_idle_cnt <= 8'd0;
         end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= 1'b0;
         r_alu_start <= 1'b0;
         r_op_drop   <= 1'b0;
      end else begin
         r_pend      <= w_pend_d;
         r_alu_start <= w_issue;
         r_op_drop   <= w_drop;
      end
   end

   assign alu_start  = r_alu_start;
   assign op_grant   = r_alu_start;
   assign op_drop    = r_op_drop;
   assign alu_pwr_en = r_pwr_en;
   assign iso_en     = r_iso_en;
   assign alu_rst_n  = r_alu_rst_n;
   assign ready      = r_ready;
   assign pwr_state  = r_state;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Bench for alu_pwr_seq: directed scenario tasks plus a randomized run against
// a cycle-level behavioural model built from state ages and idle-since-activity counts.
module tb_alu_pwr_seq;

   localparam int RAMP = 8;
   localparam int IDLE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_on = 1'b0;
   logic       op_req = 1'b0;
   logic       alu_busy = 1'b0;
   logic       alu_start, op_grant, op_drop, alu_pwr_en, iso_en, alu_rst_n, ready;
   logic [2:0] pwr_state;
   logic       b_alu_start, b_op_grant, b_op_drop, b_alu_pwr_en, b_iso_en, b_alu_rst_n, b_ready;
   logic [2:0] b_pwr_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_pwr_seq #(.RAMP_CYCLES(RAMP), .IDLE_CYCLES(IDLE)) dut (
      .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .op_req(op_req), .alu_busy(alu_busy),
      .alu_start(alu_start), .op_grant(op_grant), .op_drop(op_drop),
      .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_rst_n(alu_rst_n),
      .ready(ready), .pwr_state(pwr_state)
   );

   // Boundary instance: shortest ramp, auto power-down disabled.
   alu_pwr_seq #(.RAMP_CYCLES(1), .IDLE_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .op_req(op_req), .alu_busy(alu_busy),
      .alu_start(b_alu_start), .op_grant(b_op_grant), .op_drop(b_op_drop),
      .alu_pwr_en(b_alu_pwr_en), .iso_en(b_iso_en), .alu_rst_n(b_alu_rst_n),
      .ready(b_ready), .pwr_state(b_pwr_state)
   );

   // Reference model: m_age = edges spent in current state, m_idle = quiet edges in ON.
   int m_st, m_age, m_idle, m_nxt;
   bit m_pend, m_start, m_drop;
   bit m_issue, m_active;

   function automatic int model_next(int st, int age, int idle, bit pend, bit sw, bit req,
                                     bit busy);
      case (st)
         0:       return (sw || req || pend) ? 1 : 0;
         1:       return (age + 1 >= RAMP) ? 2 : 1;
         2:       return 3;
         3:       return (IDLE != 0 && !sw && !pend && !busy && !req && idle >= IDLE) ? 4 : 3;
         4:       return 5;
         default: return 0;
      endcase
   endfunction

   function automatic logic [9:0] model_vec(int st, bit start, bit drop);
      return {3'(st), st != 0, st != 3, (st >= 2 && st <= 4), st == 3, start, start, drop};
   endfunction

   always_comb begin
      m_issue  = (m_st == 3) && m_pend && !alu_busy;
      m_active = sw_on || m_pend || op_req || alu_busy || m_start;
      m_nxt    = model_next(m_st, m_age, m_idle, m_pend, sw_on, op_req, alu_busy);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st    <= 0;
         m_age   <= 0;
         m_idle  <= 0;
         m_pend  <= 1'b0;
         m_start <= 1'b0;
         m_drop  <= 1'b0;
      end else begin
         m_st    <= m_nxt;
         m_age   <= (m_nxt != m_st) ? 0 : m_age + 1;
         m_idle  <= (m_st != 3 || m_active) ? 0 : m_idle + 1;
         m_pend  <= m_issue ? op_req : (m_pend || op_req);
         m_start <= m_issue;
         m_drop  <= op_req && m_pend && !m_issue;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sw_on = 0; op_req = 0; alu_busy = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         if (pwr_state === s) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   function automatic logic [9:0] dut_vec();
      return {pwr_state, alu_pwr_en, iso_en, alu_rst_n, ready, alu_start, op_grant, op_drop};
   endfunction

   task automatic test_reset();
      logic [9:0] rst_v;
      rst_v = {3'd0, 3'b010, 4'b0000};
      tick(); tick();
      n_vec++;
      if (dut_vec() !== rst_v) begin
         n_err++; $display("FAIL reset_initial: got %b exp %b", dut_vec(), rst_v);
      end
      rst_n = 1;
      tick();
      op_req = 1; tick(); op_req = 0;
      n_vec++;
      if ({pwr_state, alu_pwr_en, iso_en, alu_rst_n} !== 6'b001_110) begin
         n_err++;
         $display("FAIL reset_ramp_entry: got %b exp %b",
                  {pwr_state, alu_pwr_en, iso_en, alu_rst_n}, 6'b001_110);
      end
      tick(); tick(); tick();
      rst_n = 0;
      #1;
      n_vec++;
      if (dut_vec() !== rst_v) begin
         n_err++; $display("FAIL reset_mid_ramp: got %b exp %b", dut_vec(), rst_v);
      end
      tick(); tick();
      rst_n = 1;
      tick(); tick(); tick();
      n_vec++;
      if (pwr_state !== 3'd0) begin
         n_err++; $display("FAIL reset_pend_cleared: got %0d exp 0", pwr_state);
      end
   endtask

   task automatic test_cold_wake();
      logic [2:0] exp_st;
      do_reset();
      tick(); tick();
      op_req = 1; tick(); op_req = 0;
      for (int i = 0; i < 14; i++) begin
         exp_st = (i < RAMP) ? 3'd1 : (i == RAMP) ? 3'd2 : 3'd3;
         n_vec++;
         if (pwr_state !== exp_st || {alu_start, op_grant} !== {2{i == RAMP + 2}}) begin
            n_err++;
            $display("FAIL cold_wake idx %0d: got st=%0d start=%b grant=%b exp st=%0d start=%b",
                     i, pwr_state, alu_start, op_grant, exp_st, i == RAMP + 2);
         end
         if (i == RAMP - 1 || i == RAMP || i == RAMP + 1) begin
            n_vec++;
            if ({alu_rst_n, iso_en} !== ((i == RAMP - 1) ? 2'b01 : (i == RAMP) ? 2'b11 : 2'b10))
            begin
               n_err++; $display("FAIL cold_wake_order idx %0d: got rst_n/iso %b%b", i,
                                 alu_rst_n, iso_en);
            end
         end
         exp_st = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd3;
         n_vec++;
         if (b_pwr_state !== exp_st || b_alu_start !== (i == 3)) begin
            n_err++;
            $display("FAIL cold_wake_ramp1 idx %0d: got st=%0d start=%b exp st=%0d start=%b",
                     i, b_pwr_state, b_alu_start, exp_st, i == 3);
         end
         tick();
      end
   endtask

   task automatic test_auto_shutdown();
      bit ok;
      logic [5:0] exp_v;
      logic [2:0] st_tab [0:7];
      st_tab = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
      do_reset();
      op_req = 1; tick(); op_req = 0;
      wait_state(3'd3, 20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL shutdown_wake: got timeout exp ON"); end
      tick();
      n_vec++;
      if (alu_start !== 1'b1) begin
         n_err++; $display("FAIL shutdown_issue: got %b exp 1", alu_start);
      end
      alu_busy = 1;
      tick(); tick(); tick();
      alu_busy = 0;
      for (int i = 0; i < 8; i++) begin
         exp_v = {st_tab[i], st_tab[i] != 3'd0, st_tab[i] != 3'd3, i < 6};
         n_vec++;
         if ({pwr_state, alu_pwr_en, iso_en, alu_rst_n} !== exp_v) begin
            n_err++;
            $display("FAIL shutdown_seq idx %0d: got %b exp %b", i,
                     {pwr_state, alu_pwr_en, iso_en, alu_rst_n}, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_drop_hold();
      bit ok;
      int starts, first_at;
      do_reset();
      sw_on = 1;
      wait_state(3'd3, 20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL drop_wake: got timeout exp ON"); end
      alu_busy = 1;
      op_req = 1; tick(); op_req = 0;
      n_vec++;
      if (op_drop !== 1'b0) begin n_err++; $display("FAIL drop_first: got %b exp 0", op_drop); end
      tick();
      op_req = 1; tick(); op_req = 0;
      n_vec++;
      if (op_drop !== 1'b1) begin n_err++; $display("FAIL drop_second: got %b exp 1", op_drop); end
      tick();
      n_vec++;
      if ({op_drop, alu_start} !== 2'b00) begin
         n_err++; $display("FAIL drop_pulse_width: got %b exp 00", {op_drop, alu_start});
      end
      tick(); tick();
      alu_busy = 0;
      starts = 0; first_at = -1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (alu_start === 1'b1 && op_grant === 1'b1) begin
            starts++;
            if (first_at < 0) first_at = i;
         end
      end
      n_vec++;
      if (starts != 1 || first_at != 0) begin
         n_err++; $display("FAIL drop_single_start: got %0d starts at %0d exp 1 at 0",
                           starts, first_at);
      end
      sw_on = 0;
   endtask

   task automatic test_wake_during_shutdown();
      bit ok;
      int starts, at, bad;
      do_reset();
      sw_on = 1;
      wait_state(3'd3, 20, ok);
      sw_on = 0;
      wait_state(3'd4, 20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL wake_iso_reach: got timeout exp ISO"); end
      op_req = 1; tick(); op_req = 0;
      n_vec++;
      if ({pwr_state, alu_start} !== {3'd5, 1'b0}) begin
         n_err++; $display("FAIL wake_pdn: got %b exp %b", {pwr_state, alu_start}, 4'b1010);
      end
      tick();
      n_vec++;
      if ({pwr_state, alu_start} !== 4'b0000) begin
         n_err++; $display("FAIL wake_off: got %b exp 0000", {pwr_state, alu_start});
      end
      tick();
      n_vec++;
      if (pwr_state !== 3'd1) begin
         n_err++; $display("FAIL wake_ramp: got %0d exp 1", pwr_state);
      end
      starts = 0; at = -1; bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (alu_start === 1'b1) begin
            starts++; at = i;
            if (iso_en !== 1'b0 || pwr_state !== 3'd3) bad++;
         end
         tick();
      end
      n_vec++;
      if (starts != 1 || at != RAMP + 2 || bad != 0) begin
         n_err++; $display("FAIL wake_issue: got %0d starts at %0d bad %0d exp 1 at %0d bad 0",
                           starts, at, bad, RAMP + 2);
      end
   endtask

   task automatic test_force_on();
      bit ok;
      int off_cnt, b_off;
      logic [2:0] exp_st;
      do_reset();
      sw_on = 1;
      wait_state(3'd3, 20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL force_wake: got timeout exp ON"); end
      off_cnt = 0; b_off = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (pwr_state !== 3'd3 || ready !== 1'b1) off_cnt++;
      end
      n_vec++;
      if (off_cnt != 0) begin
         n_err++; $display("FAIL force_hold: got %0d non-ON cycles exp 0", off_cnt);
      end
      sw_on = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 6) begin
            exp_st = (i < 5) ? 3'd3 : 3'd4;
            n_vec++;
            if (pwr_state !== exp_st) begin
               n_err++; $display("FAIL force_release idx %0d: got %0d exp %0d", i, pwr_state,
                                 exp_st);
            end
         end
         if (b_pwr_state !== 3'd3) b_off++;
         tick();
      end
      n_vec++;
      if (b_off != 0) begin
         n_err++; $display("FAIL idle0_never_off: got %0d non-ON cycles exp 0", b_off);
      end
   endtask

   task automatic test_random();
      logic [9:0] exp_v, got_v;
      int phase, shown;
      shown = 0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         got_v = dut_vec();
         exp_v = model_vec(m_st, m_start, m_drop);
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++;
            if (shown < 10) begin
               shown++; $display("FAIL random cyc %0d: got %b exp %b", i, got_v, exp_v);
            end
         end
         phase    = (i / 40) % 3;
         sw_on    = (phase == 2);
         op_req   = (phase == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
         alu_busy = (phase == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
         if (i == 700) rst_n = 0;
         if (i == 702) rst_n = 1;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_cold_wake();
      test_auto_shutdown();
      test_drop_hold();
      test_wake_during_shutdown();
      test_force_on();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_pwr_seq.md
# alu_pwr_seq

Power-sequencing and start-arbitration controller for the power-gated ALU domain. Drives the ALU's `alu_pwr_en`, `iso_en` and a domain reset in a fixed, glitch-free order. Wakes the domain on demand, issues queued operation starts only while the domain is fully on, and shuts the domain down after a programmable idle period. Sits between the system request logic and the ALU/result-clamp stage in `top`.

## Interface

**Parameters**

- `RAMP_CYCLES`, 8: cycles `alu_pwr_en` is high before domain reset release. Must be 1..255.
- `IDLE_CYCLES`, 64: idle cycles in ON before auto power-down. 0 disables auto power-down. Must be 0..255.

**Ports**

- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sw_on` input 1: level; while high the domain is forced on and never auto-powers-down.
- `op_req` input 1: single-cycle request to start one ALU operation.
- `alu_busy` input 1: ALU busy flag.
- `alu_start` output 1: one-cycle start pulse to the ALU.
- `op_grant` output 1: one-cycle pulse, coincident with `alu_start`.
- `op_drop` output 1: one-cycle pulse; an `op_req` was discarded.
- `alu_pwr_en` output 1: ALU domain power enable.
- `iso_en` output 1: ALU output isolation enable.
- `alu_rst_n` output 1: ALU domain reset, active-low.
- `ready` output 1: high only in ON.
- `pwr_state` output 3: current state encoding.

## Operation

- **Outputs:** all registered. Power controls are a pure function of state.
- **States** (`pwr_state` / `alu_pwr_en` / `iso_en` / `alu_rst_n`):
  - OFF = 0 / 0 / 1 / 0
  - RAMP = 1 / 1 / 1 / 0
  - REL = 2 / 1 / 1 / 1
  - ON = 3 / 1 / 0 / 1
  - ISO = 4 / 1 / 1 / 1
  - PDN = 5 / 1 / 1 / 0
- **Ordering invariants:**
  - `iso_en` rises before the reset asserts, and before power drops.
  - Power rises before the reset releases, and the reset releases before `iso_en` falls.
- **Transitions:**
  - OFF → RAMP when `sw_on | op_req | pend`.
  - RAMP → REL after `RAMP_CYCLES` cycles in RAMP. The ramp counter is cleared on RAMP entry.
  - REL → ON after 1 cycle.
  - ON → ISO when all of the following hold: `!sw_on`, `!pend`, `!alu_busy`, `!op_req`, `IDLE_CYCLES != 0`, and `idle_cnt == IDLE_CYCLES`.
  - ISO → PDN after 1 cycle.
  - PDN → OFF after 1 cycle.
- **Pending register `pend`:** one entry.
  - Set by `op_req`.
  - Cleared when a start issues.
  - `op_req` while `pend = 1` and no issue in that cycle: request discarded, `op_drop` pulses.
  - `op_req` in the same cycle as an issue: `pend` stays 1 (the new request is held).
- **Issue:** in ON, when `pend & !alu_busy`, register `alu_start = op_grant = 1` for exactly one cycle and clear `pend`. No issue in any other state.
- **Idle counter `idle_cnt`:** 8 bits.
  - Cleared on ON entry.
  - Cleared in any ON cycle with `sw_on | pend | op_req | alu_busy | alu_start`.
  - Otherwise increments in ON, saturating at `IDLE_CYCLES`.
- **`op_req` during ISO or PDN:** the sequence completes to OFF, then re-wakes immediately from OFF because `pend = 1`. Power-down is never aborted mid-sequence.
- **`sw_on` rising in ISO or PDN:** same rule; the sequence completes to OFF, then wakes.
- **Reset (async, any state, including mid-ramp or mid-operation):**
  - State OFF; `alu_pwr_en = 0`, `iso_en = 1`, `alu_rst_n = 0`.
  - `ready`, `alu_start`, `op_grant`, `op_drop` = 0; `pwr_state = 0`.
  - `pend`, `idle_cnt` and the ramp counter = 0.

## Timing

- Let `op_req` (or `sw_on`) be sampled at edge k while in OFF:
  - RAMP from edge k.
  - REL from edge k+`RAMP_CYCLES`.
  - ON from edge k+`RAMP_CYCLES`+1.
  - `alu_start` high for the cycle following edge k+`RAMP_CYCLES`+2 (with `alu_busy = 0`).
- In steady ON, with `pend` set or `op_req` sampled at edge j: `alu_start` is high after edge j+1 when `alu_busy = 0`. `op_req` is registered into `pend` first.
- After the last activity cycle in ON, `idle_cnt` reaches `IDLE_CYCLES` after `IDLE_CYCLES` edges. ISO follows one edge later. OFF is reached 2 edges after ISO.
- `op_drop` is high in the cycle after the dropped `op_req` was sampled.
- `ready` falls on the same edge as ISO entry.

## Test plan

- **Reset values:** assert `rst_n = 0` mid-RAMP → immediately `pwr_state = 0`, `alu_pwr_en = 0`, `iso_en = 1`, `alu_rst_n = 0`, `ready = 0`, no `alu_start`.
- **Cold wake:** defaults, `op_req` pulse at edge 10 →
  - `pwr_state` 1 for 8 cycles, then 2 for 1, then 3.
  - `alu_start` and `op_grant` high exactly once, after edge 20.
  - `iso_en` falls only after `alu_rst_n` has risen.
- **Auto shutdown:** `IDLE_CYCLES = 4`, one op completes, then no activity → ON for 5 cycles after the last busy cycle, then states 4, 5, 0. `iso_en` rises one cycle before `alu_rst_n` falls, and two cycles before `alu_pwr_en` falls.
- **Drop and hold:** in ON with `alu_busy = 1`, two `op_req` pulses →
  - First is held; second gives `op_drop = 1` for one cycle.
  - When `alu_busy` falls, exactly one `alu_start`.
- **Wake during shutdown:** `op_req` during ISO → passes through PDN and OFF (one cycle), then RAMP. The op issues after re-entering ON; no `alu_start` while `iso_en = 1`.
- **Force on:** `sw_on = 1` with `IDLE_CYCLES = 4` for 100 idle cycles → remains in ON. Drop `sw_on` → shutdown begins after 4 further idle cycles.
